// File: rtl/hinp_cfg_serial_rx.sv
// hinp_cfg_serial_rx: HINP serial config receiver, assembles ID/addr/data frames into register write strobes
module hinp_cfg_serial_rx #(
    parameter int ID_W    = 8,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              sinp,
    input  logic [ID_W-1:0]   chip_id,
    output logic              reg_wr,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_data,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        frame_cnt
);
    localparam int N  = ID_W + ADDR_W + DATA_W;
    localparam int CW = $clog2(N + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [2:0]        sclk_sync;
    logic [1:0]        sinp_sync;
    logic [N-1:0]      shreg;
    logic [CW-1:0]     bit_cnt;
    logic [TW-1:0]     to_cnt;
    logic              sclk_rise;
    logic              sbit;
    logic [ID_W-1:0]   id_f;
    logic              hit;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sbit      = sinp_sync[1];
    assign id_f      = shreg[N-1 -: ID_W];
    assign hit       = (id_f == chip_id) || (&id_f);

    // two-flop synchronizers; third sclk stage is the edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            sinp_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            sinp_sync <= {sinp_sync[0], sinp};
        end
    end

    // frame FSM: shift bits, time out stalled frames, decode and strobe on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            reg_wr    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sclk_rise) begin
                        shreg   <= {shreg[N-2:0], sbit};
                        bit_cnt <= CW'(1);
                        to_cnt  <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shreg   <= {shreg[N-2:0], sbit};
                        bit_cnt <= bit_cnt + CW'(1);
                        to_cnt  <= '0;
                        if (bit_cnt == CW'(N - 1))
                            state <= DONE;
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                        to_cnt    <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                DONE: begin
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                    if (hit) begin
                        reg_wr    <= 1'b1;
                        reg_addr  <= shreg[DATA_W +: ADDR_W];
                        reg_data  <= shreg[DATA_W-1:0];
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hinp_cfg_serial_rx.sv
// tb_hinp_cfg_serial_rx: randomized bench with a frame-level reference model
module tb_hinp_cfg_serial_rx;
    localparam int N = 28;
    localparam int TIMEOUT = 64;

    logic        clk = 0, rst_n = 0, sclk = 0, sinp = 0;
    logic [7:0]  chip_id = 8'h5A;
    logic        reg_wr, frame_err, busy;
    logic [3:0]  reg_addr;
    logic [15:0] reg_data;
    logic [7:0]  frame_cnt;

    hinp_cfg_serial_rx dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sinp(sinp), .chip_id(chip_id),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
        .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int asserts = 0, fails = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // capture schedule: each pin rise is captured 3 clk cycles later
    int   cap_cyc[$];
    bit   cap_bit[$];
    logic [N-1:0] m_frame;
    int   m_nbits = 0, m_last = 0, m_done = -1;
    logic [3:0]  m_addr = 0;
    logic [15:0] m_data = 0;
    logic [7:0]  m_cnt = 0;
    bit   m_wr, m_err;
    int   wr_cyc = -1, err_cyc = -1, wr_count = 0, last_raise = 0;

    // reference model and per-cycle compare
    always @(negedge clk) begin
        if (!rst_n) begin
            m_nbits = 0; m_done = -1; m_addr = 0; m_data = 0; m_cnt = 0; m_frame = 0;
            cap_cyc.delete(); cap_bit.delete();
        end else begin
            m_wr = 0; m_err = 0;
            if (m_done == cyc) begin
                if (m_frame[27:20] == chip_id || m_frame[27:20] == 8'hFF) begin
                    m_wr = 1; m_addr = m_frame[19:16]; m_data = m_frame[15:0]; m_cnt++;
                end
                m_nbits = 0; m_done = -1;
            end
            if (cap_cyc.size() > 0 && cap_cyc[0] == cyc) begin
                void'(cap_cyc.pop_front());
                m_frame = {m_frame[N-2:0], cap_bit.pop_front()};
                m_nbits++;
                m_last = cyc;
                if (m_nbits == N) m_done = cyc + 1;
            end else if (m_nbits > 0 && m_nbits < N && cyc - m_last == TIMEOUT) begin
                m_err = 1; m_nbits = 0;
            end
            chk("reg_wr", reg_wr, m_wr);
            chk("frame_err", frame_err, m_err);
            chk("busy", busy, m_nbits > 0);
            chk("reg_addr", reg_addr, m_addr);
            chk("reg_data", reg_data, m_data);
            chk("frame_cnt", frame_cnt, m_cnt);
            if (reg_wr) begin wr_cyc = cyc; wr_count++; end
            if (frame_err) err_cyc = cyc;
        end
    end

    task automatic send_bit(input bit b, input int lo, input int hi);
        sinp = b;
        repeat (lo) @(negedge clk);
        sclk = 1;
        cap_cyc.push_back(cyc + 3);
        cap_bit.push_back(b);
        last_raise = cyc;
        repeat (hi) @(negedge clk);
        sclk = 0;
    endtask

    task automatic send_bits(input logic [N-1:0] f, input int from, input int to, input int lo, input int hi);
        for (int i = from; i >= to; i--) send_bit(f[i], lo, hi);
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [3:0] a, input logic [15:0] d, input int lo, input int hi);
        send_bits({id, a, d}, N - 1, 0, lo, hi);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int k, e0, w0;
    logic [N-1:0] f;
    logic [7:0] rid;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_reg_wr", reg_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1;
        @(negedge clk);
        // addressed frame
        send_frame(8'h5A, 4'h3, 16'hBEEF, 4, 4);
        k = last_raise;
        settle(8);
        chk("t1_wr_latency", wr_cyc, k + 4);
        chk("t1_addr", reg_addr, 4'h3);
        chk("t1_data", reg_data, 16'hBEEF);
        chk("t1_cnt", frame_cnt, 1);
        // foreign ID dropped, then broadcast accepted
        w0 = wr_count;
        send_frame(8'h11, 4'h9, 16'h1234, 3, 3);
        settle(8);
        chk("t2_foreign_nowr", wr_count, w0);
        chk("t2_foreign_addr", reg_addr, 4'h3);
        send_frame(8'hFF, 4'h7, 16'h0001, 3, 3);
        settle(8);
        chk("t2_bcast_addr", reg_addr, 4'h7);
        chk("t2_bcast_data", reg_data, 16'h0001);
        chk("t2_bcast_cnt", frame_cnt, 2);
        // partial frame times out
        send_bits({8'h5A, 4'h1, 16'h0F0F}, N - 1, N - 12, 3, 3);
        k = last_raise;
        settle(80);
        chk("t3_err_time", err_cyc, k + 3 + TIMEOUT);
        chk("t3_busy", busy, 0);
        send_frame(8'h5A, 4'h2, 16'hCAFE, 3, 3);
        settle(8);
        chk("t3_recover_cnt", frame_cnt, 3);
        // edge on the expiry cycle wins
        f = {8'h5A, 4'hC, 16'hA55A};
        e0 = err_cyc;
        send_bits(f, N - 1, N - 5, 3, 3);
        send_bit(f[N - 6], 61, 3);
        send_bits(f, N - 7, 0, 3, 3);
        settle(8);
        chk("t4_edge_wins_noerr", err_cyc, e0);
        chk("t4_edge_wins_cnt", frame_cnt, 4);
        chk("t4_edge_wins_data", reg_data, 16'hA55A);
        // one cycle later the timeout wins
        send_bits(f, N - 1, N - 5, 3, 3);
        k = last_raise;
        send_bit(1'b1, 62, 3);
        settle(80);
        chk("t4_late_edge_err", err_cyc >= k + 3 + TIMEOUT, 1);
        chk("t4_late_cnt", frame_cnt, 4);
        // async reset mid-frame
        f = {8'h5A, 4'h5, 16'h5555};
        w0 = wr_count;
        send_bits(f, N - 1, N - 10, 3, 3);
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("t5_rst_addr", reg_addr, 0);
        chk("t5_rst_data", reg_data, 0);
        chk("t5_rst_cnt", frame_cnt, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_wr", reg_wr, 0);
        chk("t5_rst_err", frame_err, 0);
        @(negedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        send_bits(f, N - 11, 0, 3, 3);
        k = last_raise;
        settle(80);
        chk("t5_err_time", err_cyc, k + 3 + TIMEOUT);
        chk("t5_no_wr", wr_count, w0);
        // 256 back-to-back accepted frames wrap the counter
        w0 = wr_count;
        for (int i = 0; i < 256; i++)
            send_frame($urandom_range(0, 1) ? 8'hFF : 8'h5A, 4'($urandom), 16'($urandom), 3, 3);
        settle(8);
        chk("t6_wr_count", wr_count - w0, 256);
        chk("t6_cnt_wrap", frame_cnt, 0);
        // random frames, IDs, timing and truncation
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: rid = 8'h5A;
                1: rid = 8'hFF;
                default: rid = 8'($urandom);
            endcase
            f = {rid, 4'($urandom), 16'($urandom)};
            if ($urandom_range(0, 4) == 0) begin
                send_bits(f, N - 1, $urandom_range(1, N - 1), $urandom_range(3, 6), $urandom_range(3, 6));
                settle($urandom_range(70, 90));
            end else begin
                send_bits(f, N - 1, 0, $urandom_range(3, 6), $urandom_range(3, 6));
                settle($urandom_range(0, 40));
            end
        end
        settle(100);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
